// File: rtl/clkdiv_pkg.sv
// Shared constants, channel mode encoding and the period helper for multi_clock_divider.
package clkdiv_pkg;

    localparam int CNT_W_DEFAULT = 8;
    localparam int MAX_CH        = 8;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_DRAIN = 2'd2
    } ch_mode_e;

    // Full output period in clk_in cycles for a given divide value.
    function automatic int unsigned clkdiv_period(input int unsigned div);
        return 2 * (div + 1);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: up-counter, active/pending divide registers, enable drain and sync.
// Optional edge pulses when CLKDIV_EDGE_PULSE_EN is defined.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] div_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             sync_i,
    output logic             clk_o,
    output logic             pend_o
`ifdef CLKDIV_EDGE_PULSE_EN
    ,
    output logic             rise_o,
    output logic             fall_o
`endif
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pval_q, pval_d;
    logic             clk_q, clk_d;
    logic             pend_q, pend_d;
    logic             terminal;
    logic             apply;
    ch_mode_e         mode;

    always_comb begin
        mode     = en_i ? MODE_RUN : (clk_q ? MODE_DRAIN : MODE_IDLE);
        terminal = (cnt_q == act_q);
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        case (mode)
            MODE_RUN: begin
                if (sync_i) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                end else if (terminal) begin
                    cnt_d = '0;
                    clk_d = ~clk_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Finish the high phase at the next terminal count, then park low.
            MODE_DRAIN: begin
                if (terminal) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                clk_d = 1'b0;
            end
        endcase

        // Apply only at a falling toggle (sync included) or when parked idle.
        apply  = pend_q && ((terminal && clk_q) || (mode == MODE_IDLE));
        act_d  = apply ? pval_q : act_q;
        pend_d = pend_q && !apply;
        pval_d = pval_q;
        if (load_i) begin
            pend_d = 1'b1;
            pval_d = div_i;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            act_q  <= DEF_DIV;
            pval_q <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            act_q  <= act_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
        end
    end

    assign clk_o  = clk_q;
    assign pend_o = pend_q;

`ifdef CLKDIV_EDGE_PULSE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= clk_d & ~clk_q;
            fall_q <= clk_q & ~clk_d & ~(en_i & sync_i);
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

    // Counter never passes the half-period of the active divide value.
    a_cnt_range : assert property (@(posedge clk_in) disable iff (!reset_n)
        32'(cnt_q) < clkdiv_period(32'(act_q)) / 2);

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider with glitch-free ratio update and common sync.
// Optional rise_pls/fall_pls outputs when CLKDIV_EDGE_PULSE_EN is defined.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic [NUM_CH*CNT_W-1:0] div_cfg,
    input  logic                    cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic                    cfg_busy
`ifdef CLKDIV_EDGE_PULSE_EN
    ,
    output logic [NUM_CH-1:0]       rise_pls,
    output logic [NUM_CH-1:0]       fall_pls
`endif
);

    logic [NUM_CH-1:0] pend_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .reset_n (reset_n),
            .div_i   (div_cfg[i*CNT_W +: CNT_W]),
            .load_i  (cfg_load),
            .en_i    (ch_en[i]),
            .sync_i  (sync),
            .clk_o   (clk_out[i]),
            .pend_o  (pend_vec[i])
`ifdef CLKDIV_EDGE_PULSE_EN
            ,
            .rise_o  (rise_pls[i]),
            .fall_o  (fall_pls[i])
`endif
        );
    end

    assign cfg_busy = |pend_vec;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed table, corner sequences, random vs model.
module tb_multi_clock_divider;
    import clkdiv_pkg::*;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int DEF = 2;

    logic              clk_in = 1'b0;
    logic              reset_n;
    logic [NCH*CW-1:0] div_cfg;
    logic              cfg_load;
    logic [NCH-1:0]    ch_en;
    logic              sync;
    logic [NCH-1:0]    clk_out;
    logic              cfg_busy;
`ifdef CLKDIV_EDGE_PULSE_EN
    logic [NCH-1:0]    rise_pls;
    logic [NCH-1:0]    fall_pls;
`endif

    multi_clock_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .div_cfg  (div_cfg),
        .cfg_load (cfg_load),
        .ch_en    (ch_en),
        .sync     (sync),
        .clk_out  (clk_out),
        .cfg_busy (cfg_busy)
`ifdef CLKDIV_EDGE_PULSE_EN
        ,
        .rise_pls (rise_pls),
        .fall_pls (fall_pls)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each channel tracks cycles left in the current half period.
    int m_left[NCH];
    int m_act[NCH];
    int m_pv[NCH];
    bit m_lvl[NCH];
    bit m_pend[NCH];

    typedef struct {
        int d0, d1;
        int f0, p0, f1, p1;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_act[c]  = DEF;
            m_left[c] = DEF + 1;
            m_pv[c]   = 0;
            m_lvl[c]  = 0;
            m_pend[c] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NCH; c++) begin
            int nv;
            nv = int'(div_cfg[c*CW +: CW]);
            if (ch_en[c] && sync) begin
                if (m_pend[c] && m_lvl[c] && m_left[c] == 1) begin
                    m_act[c] = m_pv[c];
                    m_pend[c] = 0;
                end
                m_lvl[c]  = 0;
                m_left[c] = m_act[c] + 1;
            end else if (ch_en[c] || m_lvl[c]) begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    if (m_lvl[c] && m_pend[c]) begin
                        m_act[c] = m_pv[c];
                        m_pend[c] = 0;
                    end
                    m_lvl[c]  = ch_en[c] ? !m_lvl[c] : 1'b0;
                    m_left[c] = m_act[c] + 1;
                end
            end else begin
                if (m_pend[c]) begin
                    m_act[c] = m_pv[c];
                    m_pend[c] = 0;
                end
                m_lvl[c]  = 0;
                m_left[c] = m_act[c] + 1;
            end
            if (cfg_load) begin
                m_pend[c] = 1;
                m_pv[c]   = nv;
            end
        end
    endfunction

    function automatic int model_clk();
        int v = 0;
        for (int c = 0; c < NCH; c++) if (m_lvl[c]) v |= (1 << c);
        return v;
    endfunction

    function automatic int model_busy();
        int b = 0;
        for (int c = 0; c < NCH; c++) if (m_pend[c]) b = 1;
        return b;
    endfunction

    task automatic cycle();
        @(posedge clk_in);
        if (reset_n) model_step();
        else model_reset();
        #1;
        chk("model_clk_out", int'(clk_out), model_clk());
        chk("model_cfg_busy", int'(cfg_busy), model_busy());
    endtask

    task automatic wait_val(input int ch, input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            cycle();
            if (clk_out[ch] == val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic measure(input int budget, output int f0, output int p0,
                           output int f1, output int p1);
        int first[NCH];
        int per[NCH];
        logic [NCH-1:0] prev;
        for (int c = 0; c < NCH; c++) begin
            first[c] = -1;
            per[c]   = -1;
        end
        prev = clk_out;
        for (int n = 1; n <= budget; n++) begin
            cycle();
            for (int c = 0; c < NCH; c++) begin
                if (clk_out[c] && !prev[c]) begin
                    if (first[c] < 0) first[c] = n;
                    else if (per[c] < 0) per[c] = n - first[c];
                end
            end
            prev = clk_out;
            if (per[0] >= 0 && per[1] >= 0) break;
        end
        f0 = first[0];
        p0 = per[0];
        f1 = first[1];
        p1 = per[1];
    endtask

    task automatic idle_all();
        int n;
        ch_en = '0;
        for (int c = 0; c < NCH; c++) wait_val(c, 1'b0, 600, n);
        cycle();
    endtask

    task automatic load_cfg(input int d0, input int d1);
        div_cfg  = {CW'(d1), CW'(d0)};
        cfg_load = 1'b1;
        cycle();
        cfg_load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int f0, p0, f1, p1, n, bad;

        tbl[0] = '{d0: 2,   d1: 1, f0: 3,   p0: 6,   f1: 2, p1: 4};
        tbl[1] = '{d0: 0,   d1: 0, f0: 1,   p0: 2,   f1: 1, p1: 2};
        tbl[2] = '{d0: 5,   d1: 3, f0: 6,   p0: 12,  f1: 4, p1: 8};
        tbl[3] = '{d0: 255, d1: 0, f0: 256, p0: 512, f1: 1, p1: 2};
        tbl[4] = '{d0: 0,   d1: 7, f0: 1,   p0: 2,   f1: 8, p1: 16};

        reset_n  = 1'b1;
        ch_en    = 2'b11;
        div_cfg  = '0;
        cfg_load = 1'b0;
        sync     = 1'b0;
        model_reset();

        // Reset, then release with both channels already enabled.
        #2 reset_n = 1'b0;
        repeat (3) cycle();
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_busy", int'(cfg_busy), 0);
        reset_n = 1'b1;
        measure(100, f0, p0, f1, p1);
        chk("rel_first0", f0, 3);
        chk("rel_period0", p0, 6);
        chk("rel_first1", f1, 3);
        chk("rel_period1", p1, 6);
        chk("rel_busy", int'(cfg_busy), 0);

        // Table: load while idle, enable, measure first rise and period.
        for (int v = 0; v < 5; v++) begin
            idle_all();
            load_cfg(tbl[v].d0, tbl[v].d1);
            chk("tbl_busy_set", int'(cfg_busy), 1);
            cycle();
            chk("tbl_busy_clr", int'(cfg_busy), 0);
            ch_en = 2'b11;
            measure(1200, f0, p0, f1, p1);
            chk("tbl_first0", f0, tbl[v].f0);
            chk("tbl_period0", p0, tbl[v].p0);
            chk("tbl_first1", f1, tbl[v].f1);
            chk("tbl_period1", p1, tbl[v].p1);
        end

        // Ratio 2 -> 5 loaded one cycle into a high phase.
        idle_all();
        load_cfg(2, 1);
        cycle();
        ch_en = 2'b01;
        wait_val(0, 1'b1, 50, n);
        cycle();
        load_cfg(5, 1);
        chk("upd_busy_set", int'(cfg_busy), 1);
        wait_val(0, 1'b0, 20, n);
        chk("upd_high_finish", n, 1);
        chk("upd_busy_drop", int'(cfg_busy), 0);
        wait_val(0, 1'b1, 50, n);
        chk("upd_low_new", n, 6);
        wait_val(0, 1'b0, 50, n);
        chk("upd_high_new", n, 6);
        wait_val(0, 1'b1, 50, n);
        chk("upd_low_new2", n, 6);

        // Disable one cycle into a high phase with div 4.
        idle_all();
        load_cfg(4, 1);
        cycle();
        ch_en = 2'b11;
        wait_val(0, 1'b1, 50, n);
        cycle();
        ch_en = 2'b10;
        wait_val(0, 1'b0, 50, n);
        chk("drain_high_len", n + 1, 5);
        bad = 0;
        repeat (20) begin
            cycle();
            if (clk_out[0]) bad++;
        end
        chk("drain_hold_low", bad, 0);

        // Sync with channels out of phase.
        idle_all();
        load_cfg(2, 1);
        cycle();
        ch_en = 2'b01;
        repeat (2) cycle();
        ch_en = 2'b11;
        repeat (5) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        chk("sync_low", int'(clk_out), 0);
        measure(100, f0, p0, f1, p1);
        chk("sync_first0", f0, 3);
        chk("sync_first1", f1, 2);
        chk("sync_period0", p0, 6);
        chk("sync_period1", p1, 4);

        // Asynchronous reset mid-high-phase with a load outstanding.
        idle_all();
        load_cfg(4, 1);
        cycle();
        ch_en = 2'b11;
        wait_val(0, 1'b1, 50, n);
        cycle();
        load_cfg(7, 7);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_clk_out", int'(clk_out), 0);
        chk("arst_busy", int'(cfg_busy), 0);
        model_reset();
        repeat (2) cycle();
        reset_n = 1'b1;
        measure(100, f0, p0, f1, p1);
        chk("arst_first0", f0, 3);
        chk("arst_period0", p0, 6);
        chk("arst_first1", f1, 3);
        chk("arst_period1", p1, 6);

        // Random traffic against the model.
        ch_en = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 39) == 0) ch_en[c] = ~ch_en[c];
            sync = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) begin
                for (int c = 0; c < NCH; c++)
                    div_cfg[c*CW +: CW] = ($urandom_range(0, 4) == 0)
                        ? CW'($urandom_range(0, 40)) : CW'($urandom_range(0, 5));
                cfg_load = 1'b1;
            end
            cycle();
            sync     = 1'b0;
            cfg_load = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
